pa_core_top: RTL and testbench

Single-issue, multicycle 32-bit processor core with a small direct-mapped instruction cache (I$) and data cache (D$), each backed by one shared miss interface to main memory. The block is the top of the core: it fetches from `boot_addr` after reset, executes a minimal integer ISA, and issues line-granular read or write requests to an external arbiter/memory, one outstanding request at a time.

---
 rtl/pa_core_top_if.sv | 28 ++
 rtl/pa_core_top.sv | 145 ++++++++++++++
 tb/tb_pa_core_top.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pa_core_top_if.sv
// pa_core_top_if: line-granular miss request/response bundle shared by the I$ and D$.
package pa_core_pkg;
    typedef struct packed {
        logic [31:0]  addr;
        logic         is_store;
        logic [127:0] data;
    } memory_request_t;
endpackage

interface pa_core_top_if;
    import pa_core_pkg::*;
    logic            icache_req_valid_miss;
    memory_request_t icache_req_info_miss;
    logic            dcache_req_valid_miss;
    memory_request_t dcache_req_info_miss;
    logic            rsp_valid_miss;
    logic            rsp_cache_id;
    logic [127:0]    rsp_data_miss;
    logic            rsp_bus_error;
    modport master (
        output icache_req_valid_miss, icache_req_info_miss, dcache_req_valid_miss, dcache_req_info_miss,
        input  rsp_valid_miss, rsp_cache_id, rsp_data_miss, rsp_bus_error
    );
    modport slave (
        input  icache_req_valid_miss, icache_req_info_miss, dcache_req_valid_miss, dcache_req_info_miss,
        output rsp_valid_miss, rsp_cache_id, rsp_data_miss, rsp_bus_error
    );
endinterface

// File: rtl/pa_core_top.sv
// pa_core_top: multicycle 32-bit core with direct-mapped I$/D$ sharing one miss port.
// Define CORE_MUL_EN to execute opcode 0x02 as MUL; otherwise it retires as a NOP.
module pa_core_top import pa_core_pkg::*; #(
    parameter int ICACHE_LINES = 4,
    parameter int DCACHE_LINES = 4,
    parameter int LINE_WIDTH   = 128
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [31:0]   boot_addr,
    pa_core_top_if.master mem
);
    localparam int IW = $clog2(ICACHE_LINES);
    localparam int DW = $clog2(DCACHE_LINES);

    typedef enum logic [2:0] {FETCH, IWAIT, EXEC, MEM, DWAIT, HALT} state_t;
    state_t state, state_nx;

    logic [31:0]           pc, ir;
    logic [31:0]           gpr [32];
    logic [LINE_WIDTH-1:0] i_data [ICACHE_LINES];
    logic [27-IW:0]        i_tag  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] i_vld;
    logic [LINE_WIDTH-1:0] d_data [DCACHE_LINES];
    logic [27-DW:0]        d_tag  [DCACHE_LINES];
    logic [DCACHE_LINES-1:0] d_vld;

    logic [6:0]            op;
    logic [31:0]           imm, a_r, b_r, x_r, alu, i_word, ld_word;
    logic [29:0]           ea;
    logic [IW-1:0]         pc_idx;
    logic [DW-1:0]         d_idx;
    logic [LINE_WIDTH-1:0] d_line, merged;
    logic                  i_hit, d_hit, is_ld, is_st, is_alu, i_rsp, d_rsp, err;

    assign op      = ir[31:25];
    assign imm     = {{17{ir[14]}}, ir[14:0]};
    assign a_r     = gpr[ir[19:15]];
    assign b_r     = gpr[ir[14:10]];
    assign x_r     = gpr[ir[24:20]];
    assign is_ld   = op == 7'h11;
    assign is_st   = op == 7'h13;
    // word address: the two byte-offset bits are dropped after the add
    assign ea      = 30'((a_r + imm) >> 2);
    assign pc_idx  = pc[4 +: IW];
    assign d_idx   = ea[2 +: DW];
    assign i_hit   = i_vld[pc_idx] && i_tag[pc_idx] == pc[31:4+IW];
    assign d_hit   = d_vld[d_idx] && d_tag[d_idx] == ea[29:2+DW];
    assign i_word  = i_data[pc_idx][{pc[3:2], 5'd0} +: 32];
    assign d_line  = d_data[d_idx];
    assign ld_word = d_line[{ea[1:0], 5'd0} +: 32];
    assign err     = mem.rsp_bus_error;
    assign i_rsp   = state == IWAIT && mem.rsp_valid_miss && !mem.rsp_cache_id;
    assign d_rsp   = state == DWAIT && mem.rsp_valid_miss && mem.rsp_cache_id;

`ifdef CORE_MUL_EN
    assign is_alu = op inside {7'h00, 7'h01, 7'h02};
    assign alu    = op == 7'h00 ? a_r + b_r : op == 7'h01 ? a_r - b_r : a_r * b_r;
`else
    assign is_alu = op inside {7'h00, 7'h01};
    assign alu    = op == 7'h00 ? a_r + b_r : a_r - b_r;
`endif

    always_comb begin
        merged = d_line;
        merged[{ea[1:0], 5'd0} +: 32] = x_r;
    end

    always_comb begin
        state_nx = state;
        case (state)
            FETCH:   state_nx = i_hit ? EXEC : IWAIT;
            IWAIT:   state_nx = !i_rsp ? IWAIT : err ? HALT : FETCH;
            EXEC:    state_nx = (is_ld || is_st) ? MEM : FETCH;
            MEM:     state_nx = (d_hit && is_ld) ? FETCH : DWAIT;
            DWAIT:   state_nx = !d_rsp ? DWAIT : err ? HALT : mem.dcache_req_info_miss.is_store ? FETCH : MEM;
            default: state_nx = HALT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= FETCH;
        else       state <= state_nx;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc                        <= boot_addr;
            ir                        <= '0;
            i_vld                     <= '0;
            d_vld                     <= '0;
            mem.icache_req_valid_miss <= 1'b0;
            mem.dcache_req_valid_miss <= 1'b0;
            mem.icache_req_info_miss  <= '0;
            mem.dcache_req_info_miss  <= '0;
            for (int i = 0; i < 32; i++) gpr[i] <= '0;
        end else begin
            mem.icache_req_valid_miss <= 1'b0;
            mem.dcache_req_valid_miss <= 1'b0;
            case (state)
                FETCH: begin
                    if (i_hit) ir <= i_word;
                    else begin
                        mem.icache_req_valid_miss <= 1'b1;
                        mem.icache_req_info_miss  <= '{addr: {4'd0, pc[31:4]}, is_store: 1'b0, data: '0};
                    end
                end
                IWAIT: if (i_rsp && !err) i_vld[pc_idx] <= 1'b1;
                EXEC: begin
                    if (is_alu) gpr[ir[24:20]] <= alu;
                    if (!(is_ld || is_st))
                        pc <= (op == 7'h30 && x_r == a_r) ? pc + imm : op == 7'h31 ? x_r + imm : pc + 32'd4;
                end
                MEM: begin
                    if (d_hit && is_ld) begin
                        gpr[ir[24:20]] <= ld_word;
                        pc             <= pc + 32'd4;
                    end else begin
                        // a store that misses allocates the line first, then returns here
                        mem.dcache_req_valid_miss <= 1'b1;
                        mem.dcache_req_info_miss  <= '{addr: {4'd0, ea[29:2]}, is_store: d_hit, data: d_hit ? merged : '0};
                    end
                end
                DWAIT: begin
                    if (d_rsp && !err) begin
                        d_vld[d_idx] <= 1'b1;
                        if (mem.dcache_req_info_miss.is_store) pc <= pc + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (i_rsp && !err) begin
            i_data[pc_idx] <= mem.rsp_data_miss;
            i_tag[pc_idx]  <= pc[31:4+IW];
        end
        if (d_rsp && !err) begin
            d_data[d_idx] <= mem.dcache_req_info_miss.is_store ? mem.dcache_req_info_miss.data : mem.rsp_data_miss;
            d_tag[d_idx]  <= ea[29:2+DW];
        end
    end
endmodule

// File: tb/tb_pa_core_top.sv
// tb_pa_core_top: scoreboard bench acting as the line memory behind the shared miss port.
module tb_pa_core_top;
    import pa_core_pkg::*;

    typedef struct {
        bit           id;
        logic [31:0]  addr;
        bit           st;
        logic [127:0] data;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  boot_addr = 32'h1000;
    exp_t         sb[$];
    logic [127:0] ram [logic [31:0]];
    int           errors = 0;
    int           checks = 0;

    pa_core_top_if bus();
    pa_core_top dut (.clock(clock), .reset(reset), .boot_addr(boot_addr), .mem(bus));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [160:0] got, input logic [160:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rins(input logic [6:0] op, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        return {op, d, a, b, 10'd0};
    endfunction

    function automatic logic [31:0] mins(input logic [6:0] op, input logic [4:0] d, input logic [4:0] a, input logic [14:0] i);
        return {op, d, a, i};
    endfunction

    task automatic push(input bit id, input logic [31:0] addr, input bit st, input logic [127:0] data);
        exp_t e;
        e.id = id; e.addr = addr; e.st = st; e.data = data;
        sb.push_back(e);
    endtask

    task automatic do_reset(input logic [31:0] ba);
        reset = 1'b1;
        boot_addr = ba;
        bus.rsp_valid_miss = 1'b0;
        bus.rsp_bus_error = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_ivalid", bus.icache_req_valid_miss, 0);
        check("rst_dvalid", bus.dcache_req_valid_miss, 0);
        check("rst_iinfo", bus.icache_req_info_miss, 0);
        check("rst_dinfo", bus.dcache_req_info_miss, 0);
        reset = 1'b0;
    endtask

    task automatic take_req(output bit found, output bit id, output memory_request_t r);
        exp_t e;
        found = 0; id = 0; r = '0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clock);
            if (bus.icache_req_valid_miss || bus.dcache_req_valid_miss) begin
                found = 1;
                id = bus.dcache_req_valid_miss;
                r = id ? bus.dcache_req_info_miss : bus.icache_req_info_miss;
                check("one_valid", bus.icache_req_valid_miss & bus.dcache_req_valid_miss, 0);
                check("req_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("req_id", id, e.id);
                    check("req_addr", r.addr, e.addr);
                    check("req_store", r.is_store, e.st);
                    check("req_data", r.data, e.data);
                end
            end
        end
        check("req_seen", found, 1);
    endtask

    // each request: a stray response with the wrong cache_id first, then the real one
    task automatic serve(input int n, input bit err_last);
        bit found, id;
        memory_request_t r;
        for (int k = 0; k < n; k++) begin
            take_req(found, id, r);
            if (!found) break;
            @(negedge clock);
            check("pulse_len", bus.icache_req_valid_miss | bus.dcache_req_valid_miss, 0);
            bus.rsp_valid_miss = 1'b1;
            bus.rsp_cache_id = !id;
            bus.rsp_data_miss = {4{32'h5555_5555}};
            @(negedge clock);
            check("quiet_wait", bus.icache_req_valid_miss | bus.dcache_req_valid_miss, 0);
            check("info_held", id ? bus.dcache_req_info_miss : bus.icache_req_info_miss, r);
            bus.rsp_cache_id = id;
            bus.rsp_bus_error = err_last && k == n - 1;
            bus.rsp_data_miss = r.is_store ? '0 : ram.exists(r.addr) ? ram[r.addr] : '1;
            if (r.is_store) ram[r.addr] = r.data;
            @(negedge clock);
            check("quiet_rsp", bus.icache_req_valid_miss | bus.dcache_req_valid_miss, 0);
            bus.rsp_valid_miss = 1'b0;
            bus.rsp_bus_error = 1'b0;
        end
    endtask

    initial begin
        bit found, id;
        int n;
        logic [31:0] mres;
        memory_request_t r;
        bus.rsp_valid_miss = 1'b0;
        bus.rsp_cache_id = 1'b0;
        bus.rsp_data_miss = '0;
        bus.rsp_bus_error = 1'b0;

        // run 1: straight-line ALU, load miss, store merge, load hit, SUB
        ram[32'h100] = {4{rins(7'h00, 5'd3, 5'd0, 5'd0)}};
        ram[32'h101] = {mins(7'h11, 5'd4, 5'd0, 15'h2008), mins(7'h13, 5'd2, 5'd0, 15'h2008),
                        rins(7'h00, 5'd2, 5'd1, 5'd0), mins(7'h11, 5'd1, 5'd0, 15'h2004)};
        ram[32'h102] = {mins(7'h13, 5'd6, 5'd0, 15'h2000), rins(7'h01, 5'd6, 5'd5, 5'd1),
                        mins(7'h13, 5'd5, 5'd0, 15'h200C), rins(7'h00, 5'd5, 5'd4, 5'd4)};
        ram[32'h200] = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
        do_reset(32'h1000);
        push(0, 32'h100, 0, '0);
        push(0, 32'h101, 0, '0);
        push(1, 32'h200, 0, '0);
        push(1, 32'h200, 1, {32'h3333_3333, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1111_1111});
        push(0, 32'h102, 0, '0);
        push(1, 32'h200, 1, {32'hBD5B_7DDE, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1111_1111});
        push(1, 32'h200, 1, {32'hBD5B_7DDE, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
        serve(7, 0);
        check("sb_empty_1", sb.size(), 0);

        // run 2: taken BEQ skips to 0x1028, then a bus error halts the core
        ram[32'h100] = {rins(7'h00, 5'd3, 5'd0, 5'd0), mins(7'h30, 5'd0, 5'd0, 15'h0020),
                        rins(7'h00, 5'd3, 5'd0, 5'd0), rins(7'h00, 5'd3, 5'd0, 5'd0)};
        do_reset(32'h1000);
        push(0, 32'h100, 0, '0);
        push(0, 32'h102, 0, '0);
        serve(2, 1);
        n = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.icache_req_valid_miss || bus.dcache_req_valid_miss) n++;
        end
        check("halt_quiet", n, 0);
        check("sb_empty_2", sb.size(), 0);

        // run 3: reset aborts a pending fetch; MUL, not-taken BEQ, store of the product
        ram[32'h400] = {mins(7'h30, 5'd7, 5'd0, 15'h0100), rins(7'h02, 5'd7, 5'd7, 5'd8),
                        mins(7'h11, 5'd8, 5'd0, 15'h3004), mins(7'h11, 5'd7, 5'd0, 15'h3000)};
        ram[32'h401] = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mins(7'h13, 5'd7, 5'd0, 15'h3008)};
        ram[32'h300] = {32'd0, 32'd0, 32'd6, 32'd7};
        do_reset(32'h4000);
        push(0, 32'h400, 0, '0);
        take_req(found, id, r);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        bus.rsp_valid_miss = 1'b1;
        bus.rsp_cache_id = 1'b0;
        bus.rsp_data_miss = '0;
        @(posedge clock);
        #1 bus.rsp_valid_miss = 1'b0;
`ifdef CORE_MUL_EN
        mres = 32'd42;
`else
        mres = 32'd7;
`endif
        push(0, 32'h400, 0, '0);
        push(1, 32'h300, 0, '0);
        push(0, 32'h401, 0, '0);
        push(1, 32'h300, 1, {32'd0, mres, 32'd6, 32'd7});
        serve(4, 0);
        check("sb_empty_3", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
